// File: rtl/alu_pkg.sv
// Shared types for the execute-stage issue controller: ALU select codes,
// accepted opcodes and the issue FSM states.
package alu_pkg;

    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] OPC_OPIMM = 7'h13;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'h00,
        ALU_SUB    = 5'h01,
        ALU_SLL    = 5'h02,
        ALU_SLT    = 5'h03,
        ALU_SLTU   = 5'h04,
        ALU_XOR    = 5'h05,
        ALU_SRL    = 5'h06,
        ALU_SRA    = 5'h07,
        ALU_OR     = 5'h08,
        ALU_AND    = 5'h09,
        ALU_DIV    = 5'h12,
        ALU_DIVU   = 5'h13,
        ALU_REM    = 5'h14,
        ALU_REMU   = 5'h15,
        ALU_MULHU  = 5'h18,
        ALU_MULHSU = 5'h19,
        ALU_MUL    = 5'h1E,
        ALU_MULH   = 5'h1F
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESULT
    } issue_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue, ALU-side and writeback signals of the issue controller.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// never waits on ready, and payload is held stable while valid && !ready.
interface alu_issue_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;

    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [4:0]  alu_sel;
    logic        alu_rst;
    logic [31:0] alu_dataD;
    logic        alu_ready;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        illegal;

    modport master (
        input  in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, rd_addr,
        input  alu_dataD, alu_ready, out_ready,
        output in_ready, alu_dataA, alu_dataB, alu_sel, alu_rst,
        output out_valid, out_rd, out_data, illegal
    );

    modport slave (
        output in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, rd_addr,
        output alu_dataD, alu_ready, out_ready,
        input  in_ready, alu_dataA, alu_dataB, alu_sel, alu_rst,
        input  out_valid, out_rd, out_data, illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational map from opcode/funct3/funct7 to the ALU select code, plus
// flags for multi-cycle ops, immediate operand and legality.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    sel,
    output logic       is_mul_div,
    output logic       use_imm,
    output logic       legal
);

    alu_op_e base_sel;

    always_comb begin
        case (funct3)
            3'd0:    base_sel = ALU_ADD;
            3'd1:    base_sel = ALU_SLL;
            3'd2:    base_sel = ALU_SLT;
            3'd3:    base_sel = ALU_SLTU;
            3'd4:    base_sel = ALU_XOR;
            3'd5:    base_sel = ALU_SRL;
            3'd6:    base_sel = ALU_OR;
            default: base_sel = ALU_AND;
        endcase
    end

    always_comb begin
        sel        = base_sel;
        is_mul_div = 1'b0;
        use_imm    = 1'b0;
        legal      = 1'b0;
        if (opcode == OPC_OP) begin
            if (funct7 == F7_MULDIV) begin
                legal      = 1'b1;
                is_mul_div = 1'b1;
                case (funct3)
                    3'd0:    sel = ALU_MUL;
                    3'd1:    sel = ALU_MULH;
                    3'd2:    sel = ALU_MULHSU;
                    3'd3:    sel = ALU_MULHU;
                    3'd4:    sel = ALU_DIV;
                    3'd5:    sel = ALU_DIVU;
                    3'd6:    sel = ALU_REM;
                    default: sel = ALU_REMU;
                endcase
            end else if (funct7 == F7_BASE) begin
                legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
                // Only SUB and SRA have an alternate-funct7 encoding.
                if (funct3 == 3'd0) begin
                    legal = 1'b1;
                    sel   = ALU_SUB;
                end else if (funct3 == 3'd5) begin
                    legal = 1'b1;
                    sel   = ALU_SRA;
                end
            end
        end else if (opcode == OPC_OPIMM) begin
            use_imm = 1'b1;
            if (funct3 == 3'd1) begin
                legal = (funct7 == F7_BASE);
            end else if (funct3 == 3'd5) begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT) begin
                    legal = 1'b1;
                    sel   = ALU_SRA;
                end
            end else begin
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: latches one instruction, drives the ALU,
// waits out multi-cycle ops and hands the result to writeback.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.master bus,
    output issue_state_e     fsm_state
);

    issue_state_e state;
    alu_op_e      dec_sel;
    alu_op_e      sel_q;
    logic         dec_mul_div;
    logic         dec_use_imm;
    logic         dec_legal;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         alu_rst_q;
    logic         illegal_q;
    logic [31:0]  data_a_q;
    logic [31:0]  data_b_q;
    logic [31:0]  out_data_q;
    logic [4:0]   out_rd_q;
    logic         accept;
    logic [31:0]  operand_b;

    alu_op_decode u_decode (
        .opcode     (bus.opcode),
        .funct3     (bus.funct3),
        .funct7     (bus.funct7),
        .sel        (dec_sel),
        .is_mul_div (dec_mul_div),
        .use_imm    (dec_use_imm),
        .legal      (dec_legal)
    );

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        operand_b = bus.rs2_data;
        if (dec_use_imm) begin
            operand_b = is_shift(dec_sel) ? {27'b0, bus.imm[4:0]} : bus.imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_rst_q   <= 1'b0;
            illegal_q   <= 1'b0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            sel_q       <= ALU_ADD;
            out_data_q  <= '0;
            out_rd_q    <= '0;
        end else begin
            alu_rst_q <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!dec_legal) begin
                            illegal_q <= 1'b1;
                        end else begin
                            data_a_q   <= bus.rs1_data;
                            data_b_q   <= operand_b;
                            sel_q      <= dec_sel;
                            out_rd_q   <= bus.rd_addr;
                            in_ready_q <= 1'b0;
                            if (dec_mul_div) begin
                                alu_rst_q <= 1'b1;
                                state     <= ST_LAUNCH;
                            end else begin
                                state <= ST_EXEC;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    out_data_q  <= bus.alu_dataD;
                    out_valid_q <= 1'b1;
                    state       <= ST_RESULT;
                end
                ST_LAUNCH: state <= ST_WAIT_BUSY;
                // A ready still high right after launch is stale; wait for it to drop.
                ST_WAIT_BUSY: begin
                    if (!bus.alu_ready) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.alu_ready) begin
                        out_data_q  <= bus.alu_dataD;
                        out_valid_q <= 1'b1;
                        state       <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.alu_dataA = data_a_q;
    assign bus.alu_dataB = data_b_q;
    assign bus.alu_sel   = sel_q;
    assign bus.alu_rst   = alu_rst_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;
    assign bus.illegal   = illegal_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stub, instruction-level reference
// model with an expected-result queue, directed cases and random traffic.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    issue_state_e fsm_state;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int unsigned n_compared = 0;
    int unsigned n_mismatch = 0;

    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];
    int unsigned exp_illegal = 0;
    int unsigned exp_launch = 0;
    int unsigned illegal_seen = 0;
    int unsigned alu_rst_cnt = 0;
    int unsigned out_cnt = 0;
    logic [31:0] last_out = '0;
    logic [31:0] cur_a, cur_b;
    logic [4:0]  cur_sel;
    bit          have_cur = 0;

    bit   bp_mode = 0;
    logic forced_ready = 1'b1;
    logic rand_ready = 1'b1;

    localparam logic [4:0] BASE_TAB [8] = '{5'h00, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08, 5'h09};
    localparam logic [4:0] M_TAB    [8] = '{5'h1E, 5'h1F, 5'h19, 5'h18, 5'h12, 5'h13, 5'h14, 5'h15};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32IM arithmetic as seen at the ALU, including divide corner cases.
    function automatic logic [31:0] alu_ref(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (sel)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a << b[4:0];
            5'h03: return {31'b0, sa < sb};
            5'h04: return {31'b0, a < b};
            5'h05: return a ^ b;
            5'h06: return a >> b[4:0];
            5'h07: return 32'(sa >>> b[4:0]);
            5'h08: return a | b;
            5'h09: return a & b;
            5'h1E: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            5'h1F: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            5'h19: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            5'h18: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'h12: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            5'h13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h14: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            5'h15: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void ref_decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                       output bit legal, output bit is_m, output logic [4:0] sel);
        legal = 0;
        is_m  = 0;
        sel   = BASE_TAB[f3];
        if (opc == 7'h33) begin
            if (f7 == 7'h01) begin
                legal = 1; is_m = 1; sel = M_TAB[f3];
            end else if (f7 == 7'h00) begin
                legal = 1;
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                legal = 1; sel = 5'h01;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                legal = 1; sel = 5'h07;
            end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            else if (f3 == 3'd5) begin
                if (f7 == 7'h00) legal = 1;
                else if (f7 == 7'h20) begin legal = 1; sel = 5'h07; end
            end else legal = 1;
        end
    endfunction

    // ALU stub: after a launch pulse, ready stays high 1-3 cycles, then drops
    // for 1-5 busy cycles; the result is only visible while idle.
    int unsigned stub_phase, stub_delay, stub_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_phase <= 0;
        end else if (bus.alu_rst) begin
            stub_phase <= 1;
            stub_delay <= $urandom_range(0, 2);
            stub_busy  <= $urandom_range(1, 5);
        end else if (stub_phase == 1) begin
            if (stub_delay == 0) stub_phase <= 2;
            else stub_delay <= stub_delay - 1;
        end else if (stub_phase == 2) begin
            if (stub_busy <= 1) stub_phase <= 0;
            else stub_busy <= stub_busy - 1;
        end
    end
    assign bus.alu_ready = (stub_phase != 2);
    assign bus.alu_dataD = (stub_phase == 0) ? alu_ref(bus.alu_sel, bus.alu_dataA, bus.alu_dataB) : 32'hDEAD_BEEF;

    assign bus.out_ready = bp_mode ? rand_ready : forced_ready;
    always @(posedge clk) begin
        #1 rand_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.alu_rst) alu_rst_cnt++;
            if (bus.illegal) illegal_seen++;
            if (!bus.in_ready && have_cur) begin
                check_eq("alu_dataA", bus.alu_dataA, cur_a);
                check_eq("alu_dataB", bus.alu_dataB, cur_b);
                check_eq("alu_sel", {27'b0, bus.alu_sel}, {27'b0, cur_sel});
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", {31'b0, bus.out_valid}, 32'h0);
                end else begin
                    check_eq("out_data", bus.out_data, exp_q[0]);
                    check_eq("out_rd", {27'b0, bus.out_rd}, {27'b0, exp_rd_q[0]});
                    if (bus.out_ready) begin
                        last_out = bus.out_data;
                        out_cnt++;
                        void'(exp_q.pop_front());
                        void'(exp_rd_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] rd);
        bit          legal, is_m;
        logic [4:0]  sel;
        logic [31:0] bv;
        int          n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.imm      = im;
        bus.rd_addr  = rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 300);
        check_eq("accept_wait", {31'b0, bus.in_ready}, 32'h1);
        ref_decode(opc, f3, f7, legal, is_m, sel);
        if (opc == 7'h13) bv = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, im[4:0]} : im;
        else bv = b;
        if (legal) begin
            cur_a = a; cur_b = bv; cur_sel = sel; have_cur = 1;
            exp_q.push_back(alu_ref(sel, a, bv));
            exp_rd_q.push_back(rd);
            if (is_m) exp_launch++;
        end else begin
            exp_illegal++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.imm      = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", {31'b0, (exp_q.size() == 0) && bus.in_ready}, 32'h1);
    endtask

    task automatic check_reset_values();
        check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check_eq("rst_alu_rst", {31'b0, bus.alu_rst}, 32'h0);
        check_eq("rst_illegal", {31'b0, bus.illegal}, 32'h0);
        check_eq("rst_dataA", bus.alu_dataA, 32'h0);
        check_eq("rst_dataB", bus.alu_dataB, 32'h0);
        check_eq("rst_out_data", bus.out_data, 32'h0);
        check_eq("rst_sel", {27'b0, bus.alu_sel}, 32'h0);
        check_eq("rst_out_rd", {27'b0, bus.out_rd}, 32'h0);
        check_eq("rst_state", {29'b0, fsm_state}, {29'b0, ST_IDLE});
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n;
        int unsigned mark;
        logic [6:0]  opc, f7;
        logic [11:0] imm12;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.funct3   = '0;
        bus.funct7   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.imm      = '0;
        bus.rd_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;

        // ADDI 678 + (-1)
        forced_ready = 1'b1;
        mark = out_cnt;
        issue(7'h13, 3'd0, 7'h00, 32'd678, 32'd0, 32'hFFFF_FFFF, 5'd5);
        @(negedge clk);
        check_eq("addi_valid_exec", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        check_eq("addi_valid_result", {31'b0, bus.out_valid}, 32'h1);
        check_eq("addi_rd", {27'b0, bus.out_rd}, 32'd5);
        wait_drain();
        check_eq("addi_count", out_cnt - mark, 32'd1);
        check_eq("addi_data", last_out, 32'd677);

        // DIV by zero
        mark = alu_rst_cnt;
        issue(7'h33, 3'd4, 7'h01, 32'd678, 32'd0, 32'd0, 5'd7);
        @(negedge clk);
        check_eq("div_sel", {27'b0, bus.alu_sel}, 32'h12);
        check_eq("div_launch", {31'b0, bus.alu_rst}, 32'h1);
        wait_drain();
        check_eq("div_launch_count", alu_rst_cnt - mark, 32'd1);
        check_eq("div_data", last_out, 32'hFFFF_FFFF);

        // REMU by zero
        issue(7'h33, 3'd7, 7'h01, 32'd678, 32'd0, 32'd0, 5'd8);
        @(negedge clk);
        check_eq("remu_sel", {27'b0, bus.alu_sel}, 32'h15);
        wait_drain();
        check_eq("remu_data", last_out, 32'h0000_02A6);

        // MULH under back-pressure
        forced_ready = 1'b0;
        issue(7'h33, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd9);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        check_eq("mulh_valid", {31'b0, bus.out_valid}, 32'h1);
        repeat (5) begin
            @(negedge clk);
            check_eq("mulh_hold_data", bus.out_data, 32'h4000_0000);
            check_eq("mulh_hold_valid", {31'b0, bus.out_valid}, 32'h1);
            check_eq("mulh_in_ready", {31'b0, bus.in_ready}, 32'h0);
        end
        @(posedge clk);
        #1 forced_ready = 1'b1;
        wait_drain();
        check_eq("mulh_data", last_out, 32'h4000_0000);

        // Illegal: OP funct7=0x20 funct3=1
        issue(7'h33, 3'd1, 7'h20, 32'd1, 32'd2, 32'd0, 5'd3);
        @(negedge clk);
        check_eq("illegal_pulse", {31'b0, bus.illegal}, 32'h1);
        check_eq("illegal_in_ready", {31'b0, bus.in_ready}, 32'h1);
        check_eq("illegal_no_valid", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        check_eq("illegal_one_cycle", {31'b0, bus.illegal}, 32'h0);
        check_eq("illegal_no_valid2", {31'b0, bus.out_valid}, 32'h0);

        // Reset in the middle of a DIVU
        issue(7'h33, 3'd5, 7'h01, 32'd678, 32'd7, 32'd0, 5'd4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fsm_state != ST_WAIT_DONE && n < 50);
        check_eq("reach_wait_done", {29'b0, fsm_state}, {29'b0, ST_WAIT_DONE});
        #2 rst = 1'b1;
        #1 check_reset_values();
        exp_q.delete();
        exp_rd_q.delete();
        have_cur = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(7'h33, 3'd0, 7'h00, 32'd3, 32'd4, 32'd0, 5'd6);
        wait_drain();
        check_eq("after_reset_add", last_out, 32'd7);

        // Random traffic with random back-pressure
        bp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    opc = 7'h33;
                2:       opc = 7'h13;
                default: opc = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            imm12 = 12'($urandom);
            issue(opc, 3'($urandom_range(0, 7)), f7, rand_word(), rand_word(),
                  {{20{imm12[11]}}, imm12}, 5'($urandom));
        end
        wait_drain();
        bp_mode = 0;
        repeat (3) @(negedge clk);
        check_eq("illegal_total", illegal_seen, exp_illegal);
        check_eq("launch_total", alu_rst_cnt, exp_launch);
        check_eq("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
